// File: rtl/ax_rm3.sv
// ax_rm3: registered 8x8 unsigned approximate recursive multiplier (AxRM variant 3).
// Low-significance 2x2 sub-products use a cell that maps 3x3 to 7; the rest are exact.
module ax_rm3 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    output logic [15:0] Y
);

    localparam int unsigned OP_W   = 8;
    localparam int unsigned HALF_W = OP_W / 2;
    localparam int unsigned DIG_W  = HALF_W / 2;
    localparam int unsigned CELL_W = 2 * DIG_W;
    localparam int unsigned BLK_W  = 2 * HALF_W;
    localparam int unsigned RES_W  = 2 * OP_W;
    localparam int unsigned ACC_W  = RES_W + 1;

    // Exact 2x2 cell.
    function automatic logic [CELL_W-1:0] mul_e2(input logic [DIG_W-1:0] x,
                                                 input logic [DIG_W-1:0] y);
        return CELL_W'(x) * CELL_W'(y);
    endfunction

    // Approximate 2x2 cell: 3x3 yields 7, every other pair is exact.
    function automatic logic [CELL_W-1:0] mul_a2(input logic [DIG_W-1:0] x,
                                                 input logic [DIG_W-1:0] y);
        if (x == DIG_W'(3) && y == DIG_W'(3)) begin
            return CELL_W'(7);
        end
        return mul_e2(x, y);
    endfunction

    function automatic logic [CELL_W-1:0] mul_2x2(input logic [DIG_W-1:0] x,
                                                  input logic [DIG_W-1:0] y,
                                                  input logic            approx);
        return approx ? mul_a2(x, y) : mul_e2(x, y);
    endfunction

    // 4x4 block; approx_ll selects the cell for LL, approx_hi for LH/HL/HH.
    function automatic logic [BLK_W-1:0] mul_4x4(input logic [HALF_W-1:0] x,
                                                 input logic [HALF_W-1:0] y,
                                                 input logic             approx_ll,
                                                 input logic             approx_hi);
        logic [BLK_W-1:0] ll;
        logic [BLK_W-1:0] lh;
        logic [BLK_W-1:0] hl;
        logic [BLK_W-1:0] hh;
        ll = BLK_W'(mul_2x2(x[DIG_W-1:0],      y[DIG_W-1:0],      approx_ll));
        lh = BLK_W'(mul_2x2(x[DIG_W-1:0],      y[HALF_W-1:DIG_W], approx_hi));
        hl = BLK_W'(mul_2x2(x[HALF_W-1:DIG_W], y[DIG_W-1:0],      approx_hi));
        hh = BLK_W'(mul_2x2(x[HALF_W-1:DIG_W], y[HALF_W-1:DIG_W], approx_hi));
        return ll + ((lh + hl) << DIG_W) + (hh << HALF_W);
    endfunction

    logic [BLK_W-1:0] ll8_c;
    logic [BLK_W-1:0] lh8_c;
    logic [BLK_W-1:0] hl8_c;
    logic [BLK_W-1:0] hh8_c;
    logic [ACC_W-1:0] acc_c;

    logic [RES_W-1:0] y_d;
    logic [RES_W-1:0] y_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Combinational product: M4A on the low pair, M4P on the cross pairs, M4E on the high pair.
    always_comb begin
        ll8_c = mul_4x4(a[HALF_W-1:0],    b[HALF_W-1:0],    1'b1, 1'b1);
        lh8_c = mul_4x4(a[HALF_W-1:0],    b[OP_W-1:HALF_W], 1'b1, 1'b0);
        hl8_c = mul_4x4(a[OP_W-1:HALF_W], b[HALF_W-1:0],    1'b1, 1'b0);
        hh8_c = mul_4x4(a[OP_W-1:HALF_W], b[OP_W-1:HALF_W], 1'b0, 1'b0);
        acc_c = ACC_W'(ll8_c)
              + ((ACC_W'(lh8_c) + ACC_W'(hl8_c)) << HALF_W)
              + (ACC_W'(hh8_c) << OP_W);
    end

    always_comb begin
        y_d         = y_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            y_d = RES_W'(acc_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ax_rm3.sv
// Self-checking bench for ax_rm3: directed vector table, hand sequences and an exhaustive sweep.
module tb_ax_rm3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic [15:0] Y;

    int checks;
    int errors;

    ax_rm3 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .Y         (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        in_valid;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        exp_valid;
        logic [15:0] exp_y;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    // Reference: exact product minus 2*weight for every approximate cell that sees digits (3,3).
    function automatic int model(input logic [7:0] x, input logic [7:0] y);
        int err;
        err = 0;
        if (x[1:0] == 2'd3 && y[1:0] == 2'd3) err += 1;
        if (x[1:0] == 2'd3 && y[3:2] == 2'd3) err += 4;
        if (x[3:2] == 2'd3 && y[1:0] == 2'd3) err += 4;
        if (x[3:2] == 2'd3 && y[3:2] == 2'd3) err += 16;
        if (x[1:0] == 2'd3 && y[5:4] == 2'd3) err += 16;
        if (x[5:4] == 2'd3 && y[1:0] == 2'd3) err += 16;
        return int'(x) * int'(y) - 2 * err;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs, clock, then sample 1 time unit after the edge.
    task automatic apply(input logic r, input logic v, input logic [7:0] xa, input logic [7:0] xb);
        rst      = r;
        in_valid = v;
        a        = xa;
        b        = xb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exact_pairs;
        logic [7:0] pa [5];
        logic [7:0] pb [5];
        checks = 0;
        errors = 0;
        exact_pairs = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;

        vecs[0]  = '{1'b1, 1'b1, 8'd255, 8'd255, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 1'b1, 8'd255, 8'd255, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'd3,   8'd3,   1'b1, 16'd7};
        vecs[3]  = '{1'b0, 1'b1, 8'd255, 8'd255, 1'b1, 16'd64911};
        vecs[4]  = '{1'b0, 1'b1, 8'h30,  8'h03,  1'b1, 16'd112};
        vecs[5]  = '{1'b0, 1'b1, 8'd16,  8'd16,  1'b1, 16'd256};
        vecs[6]  = '{1'b0, 1'b1, 8'd2,   8'd200, 1'b1, 16'd400};
        vecs[7]  = '{1'b0, 1'b1, 8'd0,   8'd255, 1'b1, 16'd0};
        vecs[8]  = '{1'b0, 1'b1, 8'd1,   8'd255, 1'b1, 16'd255};
        vecs[9]  = '{1'b0, 1'b1, 8'd3,   8'd3,   1'b1, 16'd7};
        vecs[10] = '{1'b0, 1'b0, 8'd255, 8'd255, 1'b0, 16'd7};
        vecs[11] = '{1'b0, 1'b0, 8'd255, 8'd255, 1'b0, 16'd7};
        vecs[12] = '{1'b0, 1'b1, 8'h03,  8'h30,  1'b1, 16'd112};

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].rst, vecs[i].in_valid, vecs[i].a, vecs[i].b);
            check("vec_y", i, int'(Y), int'(vecs[i].exp_y));
            check("vec_valid", i, int'(out_valid), int'(vecs[i].exp_valid));
        end

        // Mid-stream reset discards the in-flight result, then streaming resumes.
        pa = '{8'd255, 8'd17, 8'hF3, 8'd99, 8'd3};
        pb = '{8'd255, 8'd33, 8'h3F, 8'd7,  8'd63};
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, pa[i], pb[i]);
            check("mid_y", i, int'(Y), model(pa[i], pb[i]));
            check("mid_valid", i, int'(out_valid), 1);
        end
        apply(1'b1, 1'b1, 8'd200, 8'd200);
        check("mid_rst_y", 0, int'(Y), 0);
        check("mid_rst_valid", 0, int'(out_valid), 0);
        apply(1'b0, 1'b1, 8'd255, 8'd255);
        check("post_rst_y", 0, int'(Y), 64911);
        check("post_rst_valid", 0, int'(out_valid), 1);
        apply(1'b0, 1'b0, 8'd1, 8'd1);
        check("post_hold_y", 0, int'(Y), 64911);
        check("post_hold_valid", 0, int'(out_valid), 0);

        // Exhaustive back-to-back sweep of every operand pair.
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] ab;
            ab = 16'(i);
            apply(1'b0, 1'b1, ab[15:8], ab[7:0]);
            check("sweep_y", i, int'(Y), model(ab[15:8], ab[7:0]));
            checks++;
            if (int'(Y) > int'(ab[15:8]) * int'(ab[7:0])) begin
                errors++;
                $display("FAIL sweep_bound[%0d] got %0d exceeds exact %0d", i, Y,
                         int'(ab[15:8]) * int'(ab[7:0]));
            end
            check("sweep_valid", i, int'(out_valid), 1);
            if (int'(Y) == int'(ab[15:8]) * int'(ab[7:0])) exact_pairs++;
        end
        $display("exact pairs: %0d of 65536", exact_pairs);

        apply(1'b0, 1'b0, 8'd0, 8'd0);
        check("final_valid", 0, int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
